// File: rtl/ringbuf_xfer_seq_if.sv
// Bundle of the control, FIFO-side and ring-buffer-side signals of ringbuf_xfer_seq.
// The master modport is the environment (drives inputs); the slave modport is the sequencer.
interface ringbuf_xfer_seq_if #(
    parameter int unsigned NCHAN = 16,
    parameter int unsigned DW    = 12,
    parameter int unsigned NCHIP = 6,
    parameter int unsigned SW    = 7
);
    localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int unsigned PW = (NCHIP > 1) ? $clog2(NCHIP) : 1;

    // Inputs to the sequencer
    logic                   jtag_mode;
    logic                   j_rd_fifo;
    logic                   rdy;
    logic [SW-1:0]          samp_max;
    logic [NCHAN-1:0]       chan_mask;
    logic [NCHAN*DW-1:0]    din;

    // Outputs from the sequencer
    logic [NCHAN-1:0]       rd_ena;
    logic                   wren;
    logic [DW-1:0]          dmux;
    logic [CW-1:0]          chan;
    logic [PW-1:0]          chip;
    logic [SW-1:0]          samp;
    logic                   busy;
    logic                   done;

    modport master (
        output jtag_mode, j_rd_fifo, rdy, samp_max, chan_mask, din,
        input  rd_ena, wren, dmux, chan, chip, samp, busy, done
    );

    modport slave (
        input  jtag_mode, j_rd_fifo, rdy, samp_max, chan_mask, din,
        output rd_ena, wren, dmux, chan, chip, samp, busy, done
    );
endinterface

// File: rtl/ringbuf_xfer_seq.sv
// Ring-buffer transfer sequencer: scans NCHAN channel FIFOs x NCHIP chips x (SAMP_MAX+1)
// samples, issuing one FIFO read per ready cycle and writing each word into the ring buffer
// one cycle later. JTAG mode overrides everything and hands the FIFO read strobes to JTAG.
// Optional feature: define XFER_CHAN_MASK_EN to drop ring-buffer writes for masked channels
// (FIFO reads still happen so the FIFOs stay aligned).
module ringbuf_xfer_seq #(
    parameter int unsigned NCHAN = 16,
    parameter int unsigned DW    = 12,
    parameter int unsigned NCHIP = 6,
    parameter int unsigned SW    = 7
) (
    input  logic                i_clk,
    input  logic                i_rst_b,
    ringbuf_xfer_seq_if.slave   io_xfer
);
    localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int unsigned PW = (NCHIP > 1) ? $clog2(NCHIP) : 1;

    localparam logic [CW-1:0] ChanLast = CW'(NCHAN - 1);
    localparam logic [PW-1:0] ChipLast = PW'(NCHIP - 1);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StFin,
        StHold
    } state_e;

    state_e          r_state, w_state_nxt;
    logic [CW-1:0]   r_chan, w_chan_nxt;
    logic [PW-1:0]   r_chip, w_chip_nxt;
    logic [SW-1:0]   r_samp, w_samp_nxt;
    logic [SW-1:0]   r_samp_max, w_samp_max_nxt;

    // Read-issue strobe for the current cycle
    logic            w_re;

    // Write pipeline: one cycle behind the FIFO read
    logic            r_wren, w_wren_nxt;
    logic [CW-1:0]   r_chan_rd;

    logic [NCHAN-1:0] w_rd_ena;
    logic [DW-1:0]    w_dmux;

    // State and scan-position registers
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_state    <= StIdle;
            r_chan     <= '0;
            r_chip     <= '0;
            r_samp     <= '0;
            r_samp_max <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_chan     <= w_chan_nxt;
            r_chip     <= w_chip_nxt;
            r_samp     <= w_samp_nxt;
            r_samp_max <= w_samp_max_nxt;
        end
    end

    // Next state, scan-position advance and read issue; JTAG aborts from any state
    always_comb begin
        w_state_nxt    = r_state;
        w_chan_nxt     = r_chan;
        w_chip_nxt     = r_chip;
        w_samp_nxt     = r_samp;
        w_samp_max_nxt = r_samp_max;
        w_re           = 1'b0;

        if (io_xfer.jtag_mode) begin
            w_state_nxt = StIdle;
            w_chan_nxt  = '0;
            w_chip_nxt  = '0;
            w_samp_nxt  = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_chan_nxt = '0;
                    w_chip_nxt = '0;
                    w_samp_nxt = '0;
                    if (io_xfer.rdy) begin
                        w_state_nxt    = StXfer;
                        // Transfer length is frozen here; later SAMP_MAX changes are ignored
                        w_samp_max_nxt = io_xfer.samp_max;
                    end
                end

                StXfer: begin
                    // RDY low simply holds the position, so the scan resumes where it paused
                    if (io_xfer.rdy) begin
                        w_re = 1'b1;
                        if (r_chan == ChanLast) begin
                            w_chan_nxt = '0;
                            if (r_chip == ChipLast) begin
                                w_chip_nxt = '0;
                                if (r_samp == r_samp_max) begin
                                    // Last read of the transfer; counters return to 0
                                    w_samp_nxt  = '0;
                                    w_state_nxt = StFin;
                                end else begin
                                    w_samp_nxt = r_samp + SW'(1);
                                end
                            end else begin
                                w_chip_nxt = r_chip + PW'(1);
                            end
                        end else begin
                            w_chan_nxt = r_chan + CW'(1);
                        end
                    end
                end

                StFin: begin
                    w_state_nxt = StHold;
                end

                StHold: begin
                    // Wait for the FIFOs to drain RDY before arming for the next transfer
                    if (!io_xfer.rdy) begin
                        w_state_nxt = StIdle;
                    end
                end

                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

`ifdef XFER_CHAN_MASK_EN
    // Masked channels are still read but their word is not written
    assign w_wren_nxt = w_re & ~io_xfer.chan_mask[r_chan];
`else
    logic w_unused_chan_mask;
    assign w_unused_chan_mask = ^io_xfer.chan_mask;
    assign w_wren_nxt         = w_re;
`endif

    // Write-enable pipeline and channel index matching the one-cycle FIFO read latency
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_wren    <= 1'b0;
            r_chan_rd <= '0;
        end else begin
            // w_re is already 0 under JTAG, so this also flushes the pipelined write
            r_wren <= w_wren_nxt;
            if (w_re) begin
                r_chan_rd <= r_chan;
            end
        end
    end

    // FIFO read enables: JTAG strobe fans out to every channel, otherwise one-hot on CHAN
    always_comb begin
        w_rd_ena = '0;
        if (io_xfer.jtag_mode) begin
            w_rd_ena = {NCHAN{io_xfer.j_rd_fifo}};
        end else if (w_re) begin
            w_rd_ena[r_chan] = 1'b1;
        end
    end

    // Write-data mux: DIN slice of the channel read in the previous cycle
    always_comb begin
        w_dmux = '0;
        for (int unsigned k = 0; k < NCHAN; k++) begin
            if (r_chan_rd == CW'(k)) begin
                w_dmux = io_xfer.din[k*DW +: DW];
            end
        end
    end

    assign io_xfer.rd_ena = w_rd_ena;
    assign io_xfer.wren   = r_wren & ~io_xfer.jtag_mode;
    assign io_xfer.dmux   = w_dmux;
    assign io_xfer.chan   = r_chan;
    assign io_xfer.chip   = r_chip;
    assign io_xfer.samp   = r_samp;
    assign io_xfer.busy   = (r_state == StXfer);
    assign io_xfer.done   = (r_state == StFin) & ~io_xfer.jtag_mode;

endmodule
